// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port register file with write->read bypass, busy
//              scoreboard and sequenced soft clear.          Rev 1.0
// ============================================================================
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  I_clr,
  output logic                  O_ready,
  input  logic [NRD*ADDR_W-1:0] I_raddr,
  output logic [NRD*DATA_W-1:0] O_rdata,
  output logic [NRD-1:0]        O_rbusy,
  input  logic [NWR-1:0]        I_we,
  input  logic [NWR*ADDR_W-1:0] I_waddr,
  input  logic [NWR*DATA_W-1:0] I_wdata,
  input  logic                  I_bset,
  input  logic [ADDR_W-1:0]     I_bset_addr
);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  // An address names a real, writable register (hardwired zero excluded).
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    unique case (state_q)
      IDLE: begin
        // Ascending port order lets the highest-index port win an address clash.
        for (int unsigned p = 0; p < NWR; p++) begin
          if (I_we[p] && addr_live(I_waddr[p*ADDR_W +: ADDR_W])) begin
            regs_d[I_waddr[p*ADDR_W +: ADDR_W]] = I_wdata[p*DATA_W +: DATA_W];
            busy_d[I_waddr[p*ADDR_W +: ADDR_W]] = 1'b0;
          end
        end
        if (I_bset && addr_live(I_bset_addr)) begin
          busy_d[I_bset_addr] = 1'b1;
        end
        if (I_clr) begin
          state_d = CLEAR;
          idx_d   = '0;
          busy_d  = '0;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  assign O_ready = (state_q == IDLE);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = I_raddr[k*ADDR_W +: ADDR_W];

    // Busy is deliberately not bypassed: a same-cycle clear shows next cycle.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if ((state_q == IDLE) && addr_live(ra)) begin
        rd = regs_q[ra];
        rb = busy_q[ra];
        if (BYPASS != 0) begin
          for (int unsigned p = 0; p < NWR; p++) begin
            if (I_we[p] && (I_waddr[p*ADDR_W +: ADDR_W] == ra)) begin
              rd = I_wdata[p*DATA_W +: DATA_W];
            end
          end
        end
      end
    end

    assign O_rdata[k*DATA_W +: DATA_W] = rd;
    assign O_rbusy[k]                  = rb;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// tb_regfile_mp : vector table, hand sequences and randomized traffic
// checked against an array/counter reference model of the register file.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic clr, ready, bset;
  logic [2*AW-1:0] raddr, waddr;
  logic [2*DW-1:0] rdata, wdata;
  logic [1:0]      rbusy, we;
  logic [AW-1:0]   baddr;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NRD(2), .NWR(2),
               .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .I_clr(clr), .O_ready(ready),
    .I_raddr(raddr), .O_rdata(rdata), .O_rbusy(rbusy),
    .I_we(we), .I_waddr(waddr), .I_wdata(wdata),
    .I_bset(bset), .I_bset_addr(baddr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  int            m_cnt;   // clear cycles still to run; 0 means ready

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    logic [31:0] r;
    if (m_cnt != 0 || a == 0) return 32'h0;
    r = m_regs[a];
    if (we[0] && waddr[0 +: AW] == a) r = wdata[0 +: DW];
    if (we[1] && waddr[AW +: AW] == a) r = wdata[DW +: DW];
    return r;
  endfunction

  function automatic logic m_rbusy(input logic [AW-1:0] a);
    return (m_cnt == 0 && a != 0) ? m_busy[a] : 1'b0;
  endfunction

  task automatic m_step();
    logic [AW-1:0] a;
    if (m_cnt == 0) begin
      for (int p = 0; p < 2; p++) begin
        a = waddr[p*AW +: AW];
        if (we[p] && a != 0) begin
          m_regs[a] = wdata[p*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (bset && baddr != 0) m_busy[baddr] = 1'b1;
      if (clr) begin
        m_cnt = NR;
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) for (int i = 0; i < NR; i++) m_regs[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [1:0] w, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic bs,
                        input logic [AW-1:0] ba, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                        input logic c);
    we = w; waddr = {a1, a0}; wdata = {d1, d0};
    bset = bs; baddr = ba; raddr = {r1, r0}; clr = c;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".rdata0"}, rdata[0 +: DW], m_read(raddr[0 +: AW]));
    chk({tag, ".rdata1"}, rdata[DW +: DW], m_read(raddr[AW +: AW]));
    chk({tag, ".rbusy0"}, 32'(rbusy[0]), 32'(m_rbusy(raddr[0 +: AW])));
    chk({tag, ".rbusy1"}, 32'(rbusy[1]), 32'(m_rbusy(raddr[AW +: AW])));
    chk({tag, ".ready"}, 32'(ready), 32'(m_cnt == 0));
  endtask

  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          bs;
    logic [AW-1:0] ba, ra0, ra1;
    logic [DW-1:0] er0, er1;
    logic          eb0, eb1;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h22, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 1'b1, 1'b1};
    vecs[8]  = '{2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7, 32'h33, 32'h22, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h33, 32'h33, 1'b1, 1'b1};
    vecs[10] = '{2'b10, 5'd0, 5'd3, 32'h0, 32'h44, 1'b0, 5'd0, 5'd3, 5'd0, 32'h44, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5, 32'h44, 32'hDEADBEEF, 1'b0, 1'b0};

    rst_n = 1'b0;
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset.ready", 32'(ready), 32'h1);
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.rbusy", 32'(rbusy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write/bypass, port conflict, zero register and scoreboard vectors.
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
             vecs[i].bs, vecs[i].ba, vecs[i].ra0, vecs[i].ra1, 1'b0);
      #1;
      chk($sformatf("vec%0d.rdata0", i), rdata[0 +: DW], vecs[i].er0);
      chk($sformatf("vec%0d.rdata1", i), rdata[DW +: DW], vecs[i].er1);
      chk($sformatf("vec%0d.rbusy0", i), 32'(rbusy[0]), 32'(vecs[i].eb0));
      chk($sformatf("vec%0d.rbusy1", i), 32'(rbusy[1]), 32'(vecs[i].eb1));
      chk($sformatf("vec%0d.ready", i), 32'(ready), 32'h1);
      tick();
    end

    // Asynchronous reset mid-cycle with live data and a busy bit.
    set_in(2'b00, 0, 0, 0, 0, 1'b1, 5'd9, 5'd9, 5'd5, 1'b0);
    tick();
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd9, 5'd5, 1'b0);
    #1;
    chk("prerst.rbusy0", 32'(rbusy[0]), 32'h1);
    chk("prerst.rdata1", rdata[DW +: DW], 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("asyncrst.rdata", rdata, 32'h0);
    chk("asyncrst.rbusy", 32'(rbusy), 32'h0);
    chk("asyncrst.ready", 32'(ready), 32'h1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model, including occasional clears.
    for (int i = 0; i < 400; i++) begin
      set_in(2'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ($urandom_range(0, 63) == 0));
      #1;
      cmp_model($sformatf("rnd%0d", i));
      tick();
    end

    // Soft clear: drain, fill every register, then clear under write traffic.
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 40 && m_cnt != 0; i++) tick();
    #1;
    chk("drain.ready", 32'(ready), 32'h1);
    for (int r = 1; r < 32; r += 2) begin
      set_in(2'b11, 5'(r), 5'(r + 1), $urandom | 32'h1, $urandom | 32'h1, 1'b1, 5'(r), 5'(r), 5'(r), 1'b0);
      tick();
    end
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd1, 5'd31, 1'b0);
    #1;
    cmp_model("filled");
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd1, 5'd31, 1'b1);
    tick();
    for (int i = 0; i < 32; i++) begin
      set_in(2'b11, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), $urandom, $urandom,
             1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
      #1;
      chk($sformatf("clr%0d.ready", i), 32'(ready), 32'h0);
      chk($sformatf("clr%0d.rdata", i), rdata, 32'h0);
      chk($sformatf("clr%0d.rbusy", i), 32'(rbusy), 32'h0);
      tick();
    end
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    #1;
    chk("clrdone.ready", 32'(ready), 32'h1);
    for (int a = 0; a < 32; a += 2) begin
      set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'(a), 5'(a + 1), 1'b0);
      #1;
      chk($sformatf("swept%0d.rdata", a), rdata, 32'h0);
      chk($sformatf("swept%0d.rbusy", a), 32'(rbusy), 32'h0);
      tick();
    end

    // Soft clear interrupted by reset at cycle 10.
    for (int r = 1; r < 32; r += 2) begin
      set_in(2'b11, 5'(r), 5'(r + 1), 32'hA5A50000 | 32'(r), 32'h5A5A0000 | 32'(r), 1'b0, 0, 0, 0, 1'b0);
      tick();
    end
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd2, 5'd3, 1'b0);
    #1;
    chk("refill.rdata0", rdata[0 +: DW], 32'h5A5A0001);
    chk("refill.rdata1", rdata[DW +: DW], 32'hA5A50003);
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd2, 5'd3, 1'b1);
    tick();
    set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd30, 5'd31, 1'b0);
    repeat (10) tick();
    #1;
    chk("clr10.ready", 32'(ready), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("clrrst.ready", 32'(ready), 32'h1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a += 2) begin
      set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'(a), 5'(a + 1), 1'b0);
      #1;
      chk($sformatf("postrst%0d.rdata", a), rdata, 32'h0);
      chk($sformatf("postrst%0d.ready", a), 32'(ready), 32'h1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire
